// File: rtl/cordic_sum_pkg.sv
// Shared types and constants for the CORDIC cosine-sum sequencer.
package cordic_sum_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        C_WAIT = 3'd2,
        A_WAIT = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/cordic_sum_fifo.sv
// Synchronous sample FIFO, DEPTH x FP32, show-ahead read port.
module cordic_sum_fifo
    import cordic_sum_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_wr_en,
    input  logic [FP_W-1:0] i_wr_data,
    input  logic            i_rd_en,
    output logic [FP_W-1:0] o_rd_data,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [FP_W-1:0]  r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance on accepted write/read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_rd) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/cordic_sum_sequencer.sv
// Sequences sum of cos(x_i) over a burst through shared CORDIC and FP32 adder.
// Optional watchdog enabled by defining CORDIC_SUM_TIMEOUT_EN.
module cordic_sum_sequencer
    import cordic_sum_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1023
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             cordic_start,
    output logic [FP_W-1:0]  cordic_data,
    input  logic [FP_W-1:0]  cordic_result,
    input  logic             cordic_done,
    output logic             add_enable,
    output logic [FP_W-1:0]  add_a,
    output logic [FP_W-1:0]  add_b,
    input  logic [FP_W-1:0]  add_result,
    input  logic             add_done,
    output logic [FP_W-1:0]  result,
    output logic             done,
    output logic             busy,
    output logic             error
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FP_W-1:0]  r_acc;
    logic [FP_W-1:0]  r_cordic_data;
    logic [FP_W-1:0]  r_add_a;
    logic [FP_W-1:0]  r_add_b;
    logic [FP_W-1:0]  r_result;
    logic             r_cordic_start;
    logic             r_add_enable;
    logic             r_done;
    logic             r_busy;
    logic             w_pop;
    logic             w_timeout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [FP_W-1:0]  w_fifo_rdata;

    cordic_sum_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (in_valid),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rdata),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign in_ready     = !w_fifo_full;
    assign cordic_start = r_cordic_start;
    assign cordic_data  = r_cordic_data;
    assign add_enable   = r_add_enable;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign result       = r_result;
    assign done         = r_done;
    assign busy         = r_busy;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state and FIFO pop decode; handshakes outside their wait state are dropped
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = (n == {CNT_W{1'b0}}) ? FINISH : FETCH;
                else       w_next_state = IDLE;
            end
            FETCH: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = C_WAIT;
                end else begin
                    w_next_state = FETCH;
                end
            end
            C_WAIT: begin
                if (w_timeout)        w_next_state = FINISH;
                else if (cordic_done) w_next_state = A_WAIT;
                else                  w_next_state = C_WAIT;
            end
            A_WAIT: begin
                if (w_timeout)     w_next_state = FINISH;
                else if (add_done) w_next_state = (r_cnt == CNT_ONE) ? FINISH : FETCH;
                else               w_next_state = A_WAIT;
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt          <= {CNT_W{1'b0}};
            r_acc          <= FP_ZERO;
            r_cordic_data  <= FP_ZERO;
            r_add_a        <= FP_ZERO;
            r_add_b        <= FP_ZERO;
            r_result       <= FP_ZERO;
            r_cordic_start <= 1'b0;
            r_add_enable   <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_cordic_start <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt  <= n;
                        r_acc  <= FP_ZERO;
                        r_busy <= 1'b1;
                    end
                end
                FETCH: begin
                    if (w_pop) begin
                        r_cordic_data  <= w_fifo_rdata;
                        r_cordic_start <= 1'b1;
                    end
                end
                C_WAIT: begin
                    if (w_next_state == A_WAIT) begin
                        r_add_a      <= cordic_result;
                        r_add_b      <= r_acc;
                        r_add_enable <= 1'b1;
                    end
                end
                A_WAIT: begin
                    if (w_timeout) begin
                        r_add_enable <= 1'b0;
                    end else if (add_done) begin
                        r_acc        <= add_result;
                        r_add_enable <= 1'b0;
                        r_cnt        <= r_cnt - CNT_ONE;
                    end
                end
                FINISH: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_add_enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef CORDIC_SUM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_error;

    // Watchdog counter restarts on every state change; error is sticky until next start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= {WD_W{1'b0}};
            r_error  <= 1'b0;
        end else begin
            if (w_next_state != r_state)
                r_wd_cnt <= {WD_W{1'b0}};
            else if (r_state == C_WAIT || r_state == A_WAIT)
                r_wd_cnt <= r_wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};
            else
                r_wd_cnt <= {WD_W{1'b0}};
            if (r_state == IDLE && start) r_error <= 1'b0;
            else if (w_timeout)           r_error <= 1'b1;
        end
    end

    assign w_timeout = (r_state == C_WAIT || r_state == A_WAIT) &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYC));
    assign error     = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

endmodule
